crc_mem_reader: RTL and testbench
=================================

// Module: crc_mem_reader
// PURPOSE
//  Avalon-MM read master sitting directly upstream of the 32-bit on-chip memory slave (s1).
//  On start, it streams word_count consecutive words from base_addr at one word/cycle.
//  It folds each word into a CRC-32 and reports the result to the control logic.
//  Memory read latency is exactly 1 clk: address/chipselect registered at edge N, readdata valid after edge N.
// PARAMETERS
//  ADDR_W   16            word-address width; matches memory depth 65536
//  DATA_W   32            data width; fixed at 32 (the CRC step is 32-bit parallel)
//  CNT_W    17            word_count width; allows 0..65536 words
// PORTS
//  clk             in   1       system clock
//  reset           in   1       synchronous, active-high reset
//  start           in   1       1-cycle pulse; accepted only when busy==0
//  base_addr       in   ADDR_W  first word address; sampled on accepted start
//  word_count      in   CNT_W   number of words; sampled on accepted start
//  busy            out  1       high from the cycle after an accepted start until done
//  done            out  1       1-cycle pulse; crc_out is valid from this cycle on
//  crc_out         out  32      final CRC; held until the next accepted start
//  mem_address     out  ADDR_W  to memory address
//  mem_chipselect  out  1       to memory chipselect
//  mem_write       out  1       to memory write
//  mem_byteenable  out  4       to memory byteenable; constant 4'hF
//  mem_writedata   out  DATA_W  to memory writedata
//  mem_clken       out  1       to memory clken; constant 1
//  mem_readdata    in   DATA_W  from memory readdata
// BEHAVIOUR
//  Reset values: busy=0, done=0, crc_out=0, mem_chipselect=0, mem_write=0, mem_address=0, mem_writedata=0; FSM=IDLE.
//  CRC: poly 0x04C11DB7, init 0xFFFFFFFF, no reflection, xorout 0xFFFFFFFF (CRC-32/BZIP2).
//   Each word is processed MSB first, one word per clk.
//  FSM
//   IDLE -> READ on start when word_count!=0. Latch addr_q=base_addr, remaining=word_count, crc=INIT.
//   IDLE -> DONE on start when word_count==0. crc_out = INIT^XOROUT = 0x00000000.
//   READ: drive chipselect=1, address=addr_q; then addr_q++ (16-bit wrap, 0xFFFF->0x0000) and remaining--.
//    Leave for DRAIN when the last address is issued (remaining==1).
//   Data pipeline: rd_vld_q=chipselect&~write delayed 1 clk. When rd_vld_q=1, crc<=step(crc,mem_readdata).
//   DRAIN: chipselect=0. Fold the final word, then go to DONE (or WB if the option is enabled).
//   DONE: done=1 for one clk, crc_out<=crc^XOROUT, go to IDLE. busy=0 in the DONE cycle.
//  Latency: from accepted start to done is N+2 clks (N = word_count>=1); 1 clk for N=0.
//  start while busy: ignored; no queuing.
//  Reset mid-operation: FSM returns to IDLE in the next cycle and chipselect drops immediately.
//   The in-flight read result is discarded; crc_out=0.
//  mem_write=0 in every state except WB.
// CONFIGURATION
//  CRC_WRITEBACK_EN defined:
//   Extra state WB after DRAIN, lasting one clk.
//   Drives chipselect=1, write=1, address=addr_q (the word after the last one read), writedata=final CRC.
//   Then goes to DONE; latency becomes N+3.
//   For N=0, WB writes 0x00000000 to base_addr.
//  CRC_WRITEBACK_EN undefined: no WB state; mem_write is tied 0 and mem_writedata is tied 0.
// STRUCTURE
//  Package crc_mem_pkg:
//   CRC_POLY, CRC_INIT, CRC_XOROUT localparams
//   state enum {IDLE, READ, DRAIN, WB, DONE}
//   function crc32_d32(crc, data)
//  Sub-module crc32_step: combinational 32-bit-parallel next-CRC (wraps crc32_d32). Instantiated once.
// TESTING
//  word_count=0, base_addr=0x0010 -> done 1 clk after start; crc_out=0x00000000; no chipselect.
//  Memory at 0..3 = 0x00000000, start base=0, count=4 -> 4 consecutive chipselect cycles at addresses 0,1,2,3.
//   done at start+6; crc_out equals the golden BZIP2 CRC of 16 zero bytes.
//  base=0xFFFE, count=3 -> addresses 0xFFFE, 0xFFFF, 0x0000. crc_out matches the golden model.
//  start pulsed again at start+2 while busy -> ignored; single done, result unchanged.
//  reset asserted at start+2 of a count=8 run -> next clk chipselect=0, busy=0, crc_out=0.
//   A new start then completes correctly.
//  CRC_WRITEBACK_EN, base=0x0100, count=2 -> write to 0x0102 with writedata=crc_out. done at start+5.

Source files
------------

// File: rtl/crc_mem_reader_pkg.sv
// Shared constants, FSM state type and the bit-serial CRC-32/BZIP2 word step for crc_mem_reader.
package crc_mem_pkg;

  localparam logic [31:0] CRC_POLY   = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    WB    = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Folds one 32-bit word into the running CRC, bit 31 first, no reflection.
  function automatic logic [31:0] crc32_d32(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_mem_reader_if.sv
// Avalon-MM bus between the CRC reader (master) and the on-chip memory s1 port (slave).
interface crc_mem_reader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic                clken;
  logic [DATA_W-1:0]   readdata;

  modport master (
    output address, chipselect, write, byteenable, writedata, clken,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write, byteenable, writedata, clken,
    output readdata
  );

endinterface

// File: rtl/crc_mem_reader_crc32_step.sv
// Combinational 32-bit-parallel next-CRC for one memory word.
module crc32_step
  import crc_mem_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [31:0] data,
  output logic [31:0] crc_next
);

  assign crc_next = crc32_d32(crc, data);

endmodule

// File: rtl/crc_mem_reader.sv
// Streams word_count words from base_addr over Avalon-MM and reports their CRC-32/BZIP2.
// Optional write-back of the CRC after the last word: define CRC_WRITEBACK_EN.
module crc_mem_reader
  import crc_mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 17
) (
  input  logic              clk,
  input  logic              reset,
  // Control handshake: start is a 1-cycle request taken only in IDLE (ignored otherwise,
  // never queued); busy covers the whole job; done pulses once with crc_out already valid.
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [31:0]       crc_out,
  output state_t            state_dbg,
  crc_mem_reader_if.master  mem
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [31:0]       crc_q;
  logic [31:0]       crc_next;
  logic [31:0]       crc_fold;
  logic              rd_vld_q;
  logic              cs;
`ifdef CRC_WRITEBACK_EN
  logic              wr;
  logic [DATA_W-1:0] wdata;
`endif

  crc32_step u_step (
    .crc      (crc_q),
    .data     (mem.readdata),
    .crc_next (crc_next)
  );

  // Value the CRC register will hold after this edge; used to publish the result early.
  assign crc_fold = rd_vld_q ? crc_next : crc_q;

  always_comb begin
    state_d = state_q;
    cs      = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
`ifdef CRC_WRITEBACK_EN
    wr      = 1'b0;
    wdata   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count != '0) state_d = READ;
`ifdef CRC_WRITEBACK_EN
          else                  state_d = WB;
`else
          else                  state_d = DONE;
`endif
        end
      end
      READ: begin
        cs   = 1'b1;
        busy = 1'b1;
        if (remaining_q == CNT_W'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
`ifdef CRC_WRITEBACK_EN
        state_d = WB;
`else
        state_d = DONE;
`endif
      end
`ifdef CRC_WRITEBACK_EN
      WB: begin
        busy    = 1'b1;
        cs      = 1'b1;
        wr      = 1'b1;
        wdata   = crc_q ^ CRC_XOROUT;
        state_d = DONE;
      end
`endif
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      crc_q       <= CRC_INIT;
      rd_vld_q    <= 1'b0;
      crc_out     <= '0;
    end else begin
      state_q <= state_d;
`ifdef CRC_WRITEBACK_EN
      rd_vld_q <= cs & ~wr;
`else
      rd_vld_q <= cs;
`endif
      if (state_q == IDLE && start) begin
        addr_q      <= base_addr;
        remaining_q <= word_count;
        crc_q       <= CRC_INIT;
      end else begin
        if (state_q == READ) begin
          addr_q      <= addr_q + ADDR_W'(1);
          remaining_q <= remaining_q - CNT_W'(1);
        end
        if (rd_vld_q) crc_q <= crc_next;
      end
      if (state_d == DONE) begin
        if (state_q == IDLE) crc_out <= CRC_INIT ^ CRC_XOROUT;
        else                 crc_out <= crc_fold ^ CRC_XOROUT;
      end
    end
  end

  // Reset gates the strobes combinationally so an aborted read stops on the same cycle.
  assign mem.address    = addr_q;
  assign mem.chipselect = cs & ~reset;
  assign mem.byteenable = '1;
  assign mem.clken      = 1'b1;
`ifdef CRC_WRITEBACK_EN
  assign mem.write      = wr & ~reset;
  assign mem.writedata  = wdata;
`else
  assign mem.write      = 1'b0;
  assign mem.writedata  = '0;
`endif

  assign state_dbg = state_q;

endmodule

// File: tb/tb_crc_mem_reader.sv
// Randomized self-checking bench for crc_mem_reader against a byte-level CRC and timeline model.
module tb_crc_mem_reader;
  import crc_mem_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int CW = 17;
`ifdef CRC_WRITEBACK_EN
  localparam int WB_EXTRA = 1;
`else
  localparam int WB_EXTRA = 0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic          busy, done;
  logic [31:0]   crc_out;
  state_t        state_dbg;

  always #5 clk = ~clk;

  crc_mem_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  crc_mem_reader #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .crc_out    (crc_out),
    .state_dbg  (state_dbg),
    .mem        (bus)
  );

  // Memory slave: one-cycle registered read.
  logic [31:0] mem [0:65535];
  always @(posedge clk)
    if (bus.chipselect && !bus.write) bus.readdata <= mem[bus.address];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard / model ----------------
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  bit          op_valid = 0;
  int          op_k = 0;
  int          op_n = 0;
  logic [15:0] op_base = '0;
  logic [31:0] crc_hold = '0;
  int          last_done_cyc = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {b, 24'h0};
    for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    return c;
  endfunction

  // CRC-32/BZIP2 over n words starting at base, each word sent as big-endian bytes.
  function automatic logic [31:0] model_crc(input logic [15:0] base, input int n);
    logic [31:0] c;
    logic [31:0] w;
    logic [15:0] a;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      a = base + 16'(i);
      w = mem[a];
      for (int j = 3; j >= 0; j--) c = crc_byte(c, w[8*j +: 8]);
    end
    return c ^ 32'hFFFFFFFF;
  endfunction

  // Compare process: expected bus/handshake activity derived from the job's start cycle.
  always @(negedge clk) begin
    bit          cs_e, bs_e, dn_e, wr_e;
    logic [15:0] ad_e;
    logic [31:0] wd_e;
    int          rel, lat;
    cs_e = 0; bs_e = 0; dn_e = 0; wr_e = 0; ad_e = '0; wd_e = '0;
    if (done === 1'b1) last_done_cyc = cyc;
    if (op_valid) begin
      rel  = cyc - op_k;
      lat  = ((op_n == 0) ? 1 : op_n + 2) + WB_EXTRA;
      cs_e = (rel >= 1) && (rel <= op_n);
      ad_e = op_base + 16'(rel - 1);
      if (WB_EXTRA != 0 && rel == lat - 1) begin
        cs_e = 1; wr_e = 1;
        ad_e = op_base + 16'(op_n);
        wd_e = (exp_q.size() != 0) ? exp_q[0] : 32'h0;
      end
      bs_e = (rel >= 1) && (rel < lat);
      dn_e = (rel == lat);
      if (dn_e) begin
        if (exp_q.size() != 0) crc_hold = exp_q.pop_front();
        op_valid = 0;
      end
    end
    check("busy", busy, bs_e);
    check("done", done, dn_e);
    check("chipselect", bus.chipselect, cs_e);
    check("write", bus.write, wr_e);
    if (cs_e) check("address", bus.address, ad_e);
    check("writedata", bus.writedata, wd_e);
    check("crc_out", crc_out, crc_hold);
    check("byteenable", bus.byteenable, 4'hF);
    check("clken", bus.clken, 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [15:0] b, input int n);
    @(negedge clk); #1;
    start = 1'b1; base_addr = b; word_count = CW'(n);
    op_k = cyc; op_n = n; op_base = b; op_valid = 1;
    exp_q.push_back(model_crc(b, n));
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int i;
    i = 0;
    while (op_valid && i < limit) begin
      @(negedge clk); #1;
      i++;
    end
    if (op_valid) begin
      total++; bad++;
      $display("FAIL timeout: done not seen within %0d cycles (job start %0d)", limit, op_k);
      op_valid = 0;
      exp_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    string       s;
    logic [31:0] c;
    logic [15:0] b;
    int          n;

    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;

    // Pin the byte model to the published CRC-32/BZIP2 check value.
    s = "123456789";
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) c = crc_byte(c, s[i]);
    check("model_check_value", c ^ 32'hFFFFFFFF, 32'hFC891918);

    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    // Zero-length job.
    start_op(16'h0010, 0);
    wait_done(10);
    check("n0_crc_literal", crc_out, 32'h0);
    check("n0_latency", last_done_cyc - op_k, 1 + WB_EXTRA);

    // Four zero words from address 0.
    start_op(16'h0000, 4);
    wait_done(20);
    check("zero4_latency", last_done_cyc - op_k, 6 + WB_EXTRA);

    // Address wrap at the top of memory.
    start_op(16'hFFFE, 3);
    wait_done(20);
    check("wrap_latency", last_done_cyc - op_k, 5 + WB_EXTRA);

    // Start while busy is ignored.
    start_op(16'h1234, 5);
    @(negedge clk); #1;
    start = 1'b1; base_addr = 16'h4000; word_count = CW'(9);
    @(negedge clk); #1;
    start = 1'b0;
    wait_done(30);
    check("busy_start_latency", last_done_cyc - op_k, 7 + WB_EXTRA);

    // Reset in the middle of an 8-word job.
    start_op(16'h0200, 8);
    @(negedge clk); #1;
    reset = 1'b1;
    op_valid = 0;
    exp_q.delete();
    crc_hold = 32'h0;
    @(negedge clk); #1;
    reset = 1'b0;
    start_op(16'h0200, 8);
    wait_done(30);

    // Randomized jobs.
    for (int t = 0; t < 12; t++) begin
      b = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) b = 16'hFFFF - 16'($urandom_range(0, 4));
      n = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : $urandom_range(1, 48);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_op(b, n);
      wait_done(n + 20);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
